// File: rtl/hightolow_delay_ctrl.sv
// Falling-edge path delay measurement controller: precharge high, launch a fall, count cycles to the fall.
// Optional macro HTL_SYNC_EN adds a two-flop synchronizer on path_result with count correction.
module hightolow_delay_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             path_result,
  output logic             path_input,
  output logic             ld_reg,
  output logic             fin,
  output logic             timeout,
  output logic [CNT_W-1:0] delay_count,
  output logic             busy
);

  localparam int unsigned SETTLE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    LAUNCH,
    CAPTURE,
    DONE
  } stateT;

  stateT               stateQ, stateNext;
  logic [SETTLE_W-1:0] settleCnt, settleNext, settleInc;
  logic [CNT_W-1:0]    countNext, cntInc, capCount;
  logic                pathInputNext, ldNext, finNext, timeoutNext, busyNext;
  logic                prUse;

`ifdef HTL_SYNC_EN
  logic [1:0] prSync;

  // Two-flop synchronizer; idles high to match a precharged path
  always_ff @(posedge clk) begin
    if (!rst_n) prSync <= 2'b11;
    else        prSync <= {prSync[0], path_result};
  end

  assign prUse    = prSync[1];
  // Remove the synchronizer latency so reported counts match the direct build
  assign capCount = (cntInc > CNT_W'(2)) ? (cntInc - CNT_W'(2)) : CNT_W'(1);
`else
  assign prUse    = path_result;
  assign capCount = cntInc;
`endif

  assign settleInc = settleCnt + SETTLE_W'(1);
  assign cntInc    = delay_count + CNT_W'(1);

  always_comb begin
    stateNext     = stateQ;
    settleNext    = settleCnt;
    countNext     = delay_count;
    pathInputNext = path_input;
    ldNext        = 1'b0;
    finNext       = fin;
    timeoutNext   = timeout;

    case (stateQ)
      IDLE: begin
        pathInputNext = 1'b1;
        finNext       = 1'b0;
        timeoutNext   = 1'b0;
        if (start) begin
          stateNext  = PRECHARGE;
          settleNext = '0;
        end
      end

      PRECHARGE: begin
        pathInputNext = 1'b1;
        settleNext    = prUse ? settleInc : '0;
        if (prUse && (settleInc == SETTLE_W'(SETTLE_CYC))) begin
          stateNext     = LAUNCH;
          countNext     = '0;
          pathInputNext = 1'b0;
        end
      end

      LAUNCH: begin
        pathInputNext = 1'b0;
        countNext     = cntInc;
        // A fall on the timeout edge still counts as a valid capture
        if (!prUse) begin
          stateNext = CAPTURE;
          countNext = capCount;
          ldNext    = 1'b1;
        end else if (cntInc == CNT_W'(TIMEOUT_CYC)) begin
          stateNext   = DONE;
          timeoutNext = 1'b1;
          finNext     = 1'b1;
        end
      end

      CAPTURE: begin
        pathInputNext = 1'b0;
        stateNext     = DONE;
        finNext       = 1'b1;
      end

      DONE: begin
        pathInputNext = 1'b0;
        if (!start) begin
          stateNext     = IDLE;
          finNext       = 1'b0;
          timeoutNext   = 1'b0;
          pathInputNext = 1'b1;
        end
      end

      default: begin
        stateNext     = IDLE;
        pathInputNext = 1'b1;
        finNext       = 1'b0;
        timeoutNext   = 1'b0;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ      <= IDLE;
      settleCnt   <= '0;
      delay_count <= '0;
      path_input  <= 1'b1;
      ld_reg      <= 1'b0;
      fin         <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      stateQ      <= stateNext;
      settleCnt   <= settleNext;
      delay_count <= countNext;
      path_input  <= pathInputNext;
      ld_reg      <= ldNext;
      fin         <= finNext;
      timeout     <= timeoutNext;
      busy        <= busyNext;
    end
  end

endmodule

// File: tb/tb_hightolow_delay_ctrl.sv
// Directed bench for hightolow_delay_ctrl (default build, SETTLE_CYC=4, TIMEOUT_CYC=1000).
module tb_hightolow_delay_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        path_result;
  logic        path_input;
  logic        ld_reg;
  logic        fin;
  logic        timeout;
  logic [15:0] delay_count;
  logic        busy;

  int   nAsserts = 0;
  int   nFail    = 0;
  logic ldSeen   = 1'b0;

  hightolow_delay_ctrl #(
    .CNT_W      (16),
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .path_result(path_result),
    .path_input (path_input),
    .ld_reg     (ld_reg),
    .fin        (fin),
    .timeout    (timeout),
    .delay_count(delay_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ldSeen = ldSeen | ld_reg;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkN(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    path_result = 1'b1;
    tickN(2);
    chk1("rst_path_input", path_input, 1'b1);
    chk1("rst_ld_reg", ld_reg, 1'b0);
    chk1("rst_fin", fin, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chkN("rst_delay_count", delay_count, 16'd0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("idle_busy", busy, 1'b0);

    // Basic measurement: fall sampled on the 5th LAUNCH edge
    start = 1'b1;
    tick();
    chk1("pre_busy", busy, 1'b1);
    chk1("pre_path_input", path_input, 1'b1);
    tickN(3);
    chk1("pre3_path_input", path_input, 1'b1);
    tick();
    chk1("launch_path_input", path_input, 1'b0);
    chkN("launch_count0", delay_count, 16'd0);
    tickN(4);
    chkN("launch_count4", delay_count, 16'd4);
    chk1("launch_no_ld", ld_reg, 1'b0);
    path_result = 1'b0;
    tick();
    chk1("cap_ld", ld_reg, 1'b1);
    chkN("cap_count5", delay_count, 16'd5);
    chk1("cap_fin0", fin, 1'b0);
    path_result = 1'b1;
    tick();
    chk1("done_ld0", ld_reg, 1'b0);
    chk1("done_fin", fin, 1'b1);
    chk1("done_timeout0", timeout, 1'b0);
    chkN("done_count5", delay_count, 16'd5);
    tickN(3);
    chk1("hold_fin", fin, 1'b1);
    chk1("hold_busy", busy, 1'b1);
    chk1("hold_path_input", path_input, 1'b0);
    chkN("hold_count5", delay_count, 16'd5);
    start = 1'b0;
    tick();
    chk1("ret_fin0", fin, 1'b0);
    chk1("ret_busy0", busy, 1'b0);
    chk1("ret_path_input", path_input, 1'b1);

    // Glitch in PRECHARGE resets the settle count; then fall on first LAUNCH edge
    start = 1'b1;
    tick();
    chk1("g_busy", busy, 1'b1);
    path_result = 1'b1; tick();
    path_result = 1'b1; tick();
    path_result = 1'b0; tick();
    path_result = 1'b1; tick();
    path_result = 1'b1; tick();
    path_result = 1'b1; tick();
    chk1("g_still_pre", path_input, 1'b1);
    path_result = 1'b1; tick();
    chk1("g_launch", path_input, 1'b0);
    path_result = 1'b0;
    tick();
    chk1("g_first_edge_ld", ld_reg, 1'b1);
    chkN("g_first_edge_count", delay_count, 16'd1);
    path_result = 1'b1;
    tick();
    chk1("g_fin", fin, 1'b1);
    start = 1'b0;
    tick();
    chk1("g_idle", busy, 1'b0);

    // Path stuck high: timeout after 1000 LAUNCH cycles, no ld_reg
    start  = 1'b1;
    ldSeen = 1'b0;
    tickN(5);
    chk1("to_launch", path_input, 1'b0);
    tickN(999);
    chkN("to_count999", delay_count, 16'd999);
    chk1("to_fin0", fin, 1'b0);
    tick();
    chk1("to_fin", fin, 1'b1);
    chk1("to_timeout", timeout, 1'b1);
    chkN("to_count1000", delay_count, 16'd1000);
    tickN(2);
    chk1("to_no_ld", ldSeen, 1'b0);
    chk1("to_timeout_held", timeout, 1'b1);
    start = 1'b0;
    tick();
    chk1("to_clear", timeout, 1'b0);
    chk1("to_clear_fin", fin, 1'b0);

    // Fall on the exact timeout edge: fall wins
    start = 1'b1;
    tickN(5);
    tickN(999);
    path_result = 1'b0;
    tick();
    chk1("edge_ld", ld_reg, 1'b1);
    chk1("edge_timeout0", timeout, 1'b0);
    chkN("edge_count1000", delay_count, 16'd1000);
    path_result = 1'b1;
    tick();
    chk1("edge_fin", fin, 1'b1);
    chk1("edge_done_timeout0", timeout, 1'b0);
    start = 1'b0;
    tick();

    // Reset mid-LAUNCH aborts without ld_reg
    start = 1'b1;
    tickN(5);
    tickN(2);
    chk1("r_in_launch", path_input, 1'b0);
    ldSeen = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    tick();
    chk1("r_path_input", path_input, 1'b1);
    chk1("r_busy", busy, 1'b0);
    chk1("r_fin", fin, 1'b0);
    chk1("r_timeout", timeout, 1'b0);
    chkN("r_count", delay_count, 16'd0);
    rst_n = 1'b1;
    tickN(2);
    chk1("r_no_ld", ldSeen, 1'b0);
    chk1("r_stays_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/hightolow_delay_ctrl.md
Name: hightolow_delay_ctrl

Overview:
Controller for the falling-edge path delay measurement. It is the counterpart of the low-to-high controller. It precharges the path under test high, launches a high-to-low transition on path_input, and counts clk cycles until path_result falls. It then pulses ld_reg so the downstream capture register samples, and raises fin. It also reports the measured cycle count and a timeout flag for paths that never settle.

Parameters:
CNT_W, 16, width of the delay cycle counter and delay_count output
SETTLE_CYC, 4, consecutive cycles path_result must read 1 before launch (1..255)
TIMEOUT_CYC, 1000, maximum launch-phase cycles before abort; must be < 2^CNT_W

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
start  input  1  level request; a measurement begins on a cycle where start=1 in IDLE
path_result  input  1  output of the path under test
path_input  output  1  drive into the path under test
ld_reg  output  1  one-cycle pulse: capture register load strobe
fin  output  1  measurement complete (valid or timeout), held until start=0
timeout  output  1  set with fin when the path failed to fall within TIMEOUT_CYC
delay_count  output  CNT_W  cycles from launch to observed fall; held while fin=1
busy  output  1  high in every state except IDLE

Behaviour:
- Clock is clk. Reset is synchronous, active-low, named rst_n. When rst_n=0 at a posedge, the block goes to IDLE: path_input=1, ld_reg=0, fin=0, timeout=0, delay_count=0, busy=0, settle counter=0.
- Reset mid-operation aborts immediately. No ld_reg is issued. path_input returns to 1.
- States are IDLE, PRECHARGE, LAUNCH, CAPTURE, DONE. All outputs are registered and move together with the state.
- IDLE: path_input=1. If start=1, go to PRECHARGE and clear the settle counter.
- PRECHARGE: path_input=1.
  - Settle counter increments when path_result=1 and clears to 0 when path_result=0.
  - When the counter reaches SETTLE_CYC, go to LAUNCH and clear delay_count.
  - No timeout applies in PRECHARGE.
- LAUNCH: path_input=0 from the first LAUNCH cycle. Each cycle delay_count increments by 1.
  - If path_result=0 is sampled, go to CAPTURE. delay_count stops at the value including that cycle, so a fall seen on the first LAUNCH edge yields 1.
  - If delay_count reaches TIMEOUT_CYC with path_result still 1, set timeout=1 and go to DONE with no ld_reg pulse.
  - If the fall and the timeout bound land on the same edge, the fall wins: CAPTURE, timeout=0.
- CAPTURE: ld_reg=1 for exactly this one cycle. path_input stays 0. Next state is DONE.
- DONE: fin=1, path_input stays 0, delay_count and timeout held.
  - When start=0, return to IDLE: fin=0, timeout=0, path_input=1.
  - A continuously high start does not retrigger. start must drop for at least one cycle between measurements.
- start going low during PRECHARGE, LAUNCH or CAPTURE is ignored; the measurement runs to DONE.
- delay_count never wraps because TIMEOUT_CYC < 2^CNT_W. No increment happens outside LAUNCH.

Optional Feature:
HTL_SYNC_EN
- Defined: path_result passes through a two-flop synchronizer before all FSM use. LAUNCH detection is delayed by 2 cycles. On entry to CAPTURE, delay_count is reported minus 2, saturating at 1, so counts match the unsynchronized build for clean inputs.
- Undefined: path_result is used directly. No extra latency, no correction.

Test Plan:
- Reset then start=1, path_result held 1 → PRECHARGE for 4 cycles → LAUNCH with path_input=0; drop path_result 5 cycles after launch → delay_count=5, single ld_reg pulse next cycle, then fin=1, timeout=0.
- PRECHARGE with path_result glitching 1,1,0,1,1,1,1 → launch occurs only after the final 4 consecutive ones.
- path_result stuck at 1 during LAUNCH, TIMEOUT_CYC=1000 → fin=1 and timeout=1 after 1000 LAUNCH cycles, ld_reg never asserted, delay_count=1000.
- Fall sampled on the 1st LAUNCH edge → delay_count=1. Fall on the exact timeout edge → timeout=0, ld_reg pulses.
- rst_n=0 for one cycle mid-LAUNCH → next cycle IDLE, path_input=1, all flags 0, no ld_reg.
- Hold start=1 through DONE → fin stays 1, no second measurement; start=0 for 1 cycle then 1 → new measurement begins from PRECHARGE.
